life_game_core: RTL and testbench

//  Memory-mapped Conway's Game of Life engine at bus region 0xD.

---
 rtl/life_game_core_if.sv | 16 +
 rtl/life_game_core.sv | 208 ++++++++++++++++++++
 tb/tb_life_game_core.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/life_game_core_if.sv
`default_nettype none
// ============================================================================
// Module      : life_game_if
// Description : Bus-decoder side port bundle for the Game of Life engine
// Revision    : 1.0 - initial release
// ============================================================================
interface life_game_if;
  logic        lg_we;
  logic [6:0]  lg_addr;
  logic [31:0] lg_din;
  logic [31:0] lg_out;

  modport master (output lg_we, output lg_addr, output lg_din, input  lg_out);
  modport slave  (input  lg_we, input  lg_addr, input  lg_din, output lg_out);
endinterface
`default_nettype wire

// File: rtl/life_game_core.sv
`default_nettype none
// ============================================================================
// Module      : life_game_core
// Description : Memory-mapped Conway's Game of Life engine, ROWS x 32 board,
//               one row per clock into a shadow buffer then a single commit.
//               Define LG_TORUS_EN for wrap-around edges (dead edges otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module life_game_core #(
  parameter int ROWS  = 16,
  parameter int GEN_W = 16
) (
  input  wire logic     clk,
  input  wire logic     rst,
  life_game_if.slave    bus
);

  localparam int            c_RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [c_RW-1:0] c_LAST = c_RW'(ROWS - 1);

  localparam logic [1:0] c_S_IDLE   = 2'd0;
  localparam logic [1:0] c_S_CALC   = 2'd1;
  localparam logic [1:0] c_S_COMMIT = 2'd2;
  localparam logic [1:0] c_S_WAIT   = 2'd3;

  logic [31:0]      r_board  [ROWS];
  logic [31:0]      r_shadow [ROWS];
  logic [1:0]       r_state;
  logic [c_RW-1:0]  r_row_ptr;
  logic [GEN_W-1:0] r_gen;
  logic             r_auto;
  logic [31:0]      r_period;
  logic [31:0]      r_wait_cnt;
  logic             r_wr_err;

  // ---------------------------------------------------------------- decode
  logic            w_is_reg;
  logic [3:0]      w_reg_sel;
  logic [c_RW-1:0] w_row_idx;
  logic            w_row_ok;
  logic            w_row_wr;
  logic            w_ctrl_wr;
  logic            w_status_wr;
  logic            w_period_wr;
  logic            w_busy;
  logic            w_auto_nxt;
  logic            w_start;
  logic            w_unused_ok;

  assign w_is_reg    = bus.lg_addr[6];
  assign w_reg_sel   = bus.lg_addr[5:2];
  assign w_row_idx   = bus.lg_addr[c_RW+1:2];
  assign w_row_ok    = ({1'b0, bus.lg_addr[5:2]} < 5'(ROWS));
  assign w_row_wr    = bus.lg_we & ~w_is_reg;
  assign w_ctrl_wr   = bus.lg_we & w_is_reg & (w_reg_sel == 4'd0);
  assign w_status_wr = bus.lg_we & w_is_reg & (w_reg_sel == 4'd1);
  assign w_period_wr = bus.lg_we & w_is_reg & (w_reg_sel == 4'd2);
  assign w_busy      = (r_state == c_S_CALC) || (r_state == c_S_COMMIT);
  // Decisions at COMMIT/WAIT see an AUTO write landing in the same cycle.
  assign w_auto_nxt  = w_ctrl_wr ? bus.lg_din[1] : r_auto;
  assign w_start     = w_ctrl_wr & (bus.lg_din[0] | (bus.lg_din[1] & ~r_auto));
  assign w_unused_ok = &{1'b0, bus.lg_addr[1:0]};

  // ------------------------------------------------------ neighbour rows
  logic [31:0] w_up, w_cur, w_dn;

  always_comb begin
    w_cur = r_board[r_row_ptr];
`ifdef LG_TORUS_EN
    w_up = (r_row_ptr == '0)     ? r_board[c_LAST] : r_board[r_row_ptr - 1'b1];
    w_dn = (r_row_ptr == c_LAST) ? r_board[0]      : r_board[r_row_ptr + 1'b1];
`else
    w_up = (r_row_ptr == '0)     ? 32'h0 : r_board[r_row_ptr - 1'b1];
    w_dn = (r_row_ptr == c_LAST) ? 32'h0 : r_board[r_row_ptr + 1'b1];
`endif
  end

  // Bit i of the result holds the cell at column i-1 (left) or i+1 (right).
  function automatic logic [31:0] left_of(input logic [31:0] v);
`ifdef LG_TORUS_EN
    return {v[30:0], v[31]};
`else
    return {v[30:0], 1'b0};
`endif
  endfunction

  function automatic logic [31:0] right_of(input logic [31:0] v);
`ifdef LG_TORUS_EN
    return {v[0], v[31:1]};
`else
    return {1'b0, v[31:1]};
`endif
  endfunction

  logic [31:0] w_up_l, w_up_r, w_cur_l, w_cur_r, w_dn_l, w_dn_r;
  logic [31:0] w_next_row;

  assign w_up_l  = left_of(w_up);
  assign w_up_r  = right_of(w_up);
  assign w_cur_l = left_of(w_cur);
  assign w_cur_r = right_of(w_cur);
  assign w_dn_l  = left_of(w_dn);
  assign w_dn_r  = right_of(w_dn);

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_col
      logic [3:0] w_n;
      assign w_n = 4'(w_up_l[gi])  + 4'(w_up[gi])  + 4'(w_up_r[gi])
                 + 4'(w_cur_l[gi]) + 4'(w_cur_r[gi])
                 + 4'(w_dn_l[gi])  + 4'(w_dn[gi])  + 4'(w_dn_r[gi]);
      assign w_next_row[gi] = (w_n == 4'd3) | (w_cur[gi] & (w_n == 4'd2));
    end
  endgenerate

  // ------------------------------------------------------------ sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= c_S_IDLE;
      r_row_ptr  <= '0;
      r_gen      <= '0;
      r_auto     <= 1'b0;
      r_period   <= 32'h0;
      r_wait_cnt <= 32'h0;
      r_wr_err   <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        r_board[r]  <= 32'h0;
        r_shadow[r] <= 32'h0;
      end
    end else begin
      if (w_ctrl_wr)
        r_auto <= bus.lg_din[1];
      if (w_period_wr)
        r_period <= bus.lg_din;
      if (w_status_wr && bus.lg_din[1])
        r_wr_err <= 1'b0;
      if (w_row_wr) begin
        if (w_busy)
          r_wr_err <= 1'b1;
        else if (w_row_ok)
          r_board[w_row_idx] <= bus.lg_din;
      end

      case (r_state)
        c_S_IDLE: begin
          r_row_ptr <= '0;
          if (w_start)
            r_state <= c_S_CALC;
        end
        c_S_CALC: begin
          r_shadow[r_row_ptr] <= w_next_row;
          if (r_row_ptr == c_LAST)
            r_state <= c_S_COMMIT;
          else
            r_row_ptr <= r_row_ptr + 1'b1;
        end
        c_S_COMMIT: begin
          for (int r = 0; r < ROWS; r++)
            r_board[r] <= r_shadow[r];
          r_gen     <= r_gen + 1'b1;
          r_row_ptr <= '0;
          if (!w_auto_nxt) begin
            r_state <= c_S_IDLE;
          end else if (r_period == 32'h0) begin
            r_state <= c_S_CALC;
          end else begin
            r_state    <= c_S_WAIT;
            r_wait_cnt <= r_period;
          end
        end
        c_S_WAIT: begin
          r_row_ptr <= '0;
          if (!w_auto_nxt)
            r_state <= c_S_IDLE;
          else if (r_wait_cnt <= 32'd1)
            r_state <= c_S_CALC;
          else
            r_wait_cnt <= r_wait_cnt - 32'd1;
        end
        default: r_state <= c_S_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------ read mux
  logic [15:0] w_gen16;
  logic [31:0] w_rd_data;

  assign w_gen16 = 16'(r_gen);

  always_comb begin
    w_rd_data = 32'h0;
    if (!w_is_reg) begin
      if (w_row_ok)
        w_rd_data = r_board[w_row_idx];
    end else begin
      case (w_reg_sel)
        4'd0:    w_rd_data = {30'h0, r_auto, 1'b0};
        4'd1:    w_rd_data = {w_gen16, 14'h0, r_wr_err, w_busy};
        4'd2:    w_rd_data = r_period;
        default: w_rd_data = 32'h0;
      endcase
    end
  end

  assign bus.lg_out = w_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_life_game_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_life_game_core
// Description : Randomised and directed bench for life_game_core against a
//               cell-by-cell Game of Life model; second instance checks gen wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_life_game_core;

  localparam int ROWS  = 16;
  localparam int ROWS2 = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  life_game_if bus0 ();
  life_game_if bus1 ();

  life_game_core #(.ROWS(ROWS), .GEN_W(16)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  life_game_core #(.ROWS(ROWS2), .GEN_W(2)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mb [ROWS];
  int          mgen;
  logic        mwr_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int sel, input logic [6:0] a, input logic [31:0] d);
    @(negedge clk);
    if (sel == 0) begin
      bus0.lg_we = 1'b1; bus0.lg_addr = a; bus0.lg_din = d;
    end else begin
      bus1.lg_we = 1'b1; bus1.lg_addr = a; bus1.lg_din = d;
    end
    @(negedge clk);
    bus0.lg_we = 1'b0;
    bus1.lg_we = 1'b0;
  endtask

  task automatic rd(input int sel, input logic [6:0] a, output logic [31:0] d);
    if (sel == 0) bus0.lg_addr = a; else bus1.lg_addr = a;
    #1;
    d = (sel == 0) ? bus0.lg_out : bus1.lg_out;
  endtask

  // Plain textbook rule evaluated over a 2-D grid of cells.
  task automatic model_step();
    logic [31:0] nb [ROWS];
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < 32; c++) begin
        int n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr = r + dr;
            int cc = c + dc;
            if (dr == 0 && dc == 0) continue;
`ifdef LG_TORUS_EN
            rr = (rr + ROWS) % ROWS;
            cc = (cc + 32) % 32;
`else
            if (rr < 0 || rr >= ROWS || cc < 0 || cc >= 32) continue;
`endif
            n += int'(mb[rr][cc]);
          end
        end
        nb[r][c] = (n == 3) || (mb[r][c] && n == 2);
      end
    end
    for (int r = 0; r < ROWS; r++) mb[r] = nb[r];
    mgen++;
  endtask

  function automatic logic [31:0] exp_status(input logic busy);
    logic [31:0] g;
    g = mgen;
    return {g[15:0], 14'h0, mwr_err, busy};
  endfunction

  task automatic load_board();
    for (int r = 0; r < ROWS; r++) wr(0, 7'(r * 4), mb[r]);
  endtask

  task automatic wait_idle(output int n);
    logic [31:0] s;
    n = 0;
    rd(0, 7'h44, s);
    while (s[0] && n < 200) begin
      n++;
      @(negedge clk);
      rd(0, 7'h44, s);
    end
  endtask

  task automatic compare_board(input string tag);
    logic [31:0] d;
    for (int r = 0; r < ROWS; r++) begin
      rd(0, 7'(r * 4), d);
      check($sformatf("%s_row%0d", tag, r), d, mb[r]);
    end
    rd(0, 7'h44, d);
    check($sformatf("%s_status", tag), d, exp_status(1'b0));
  endtask

  task automatic step_check(input string tag);
    int n;
    wr(0, 7'h40, 32'h1);
    wait_idle(n);
    check($sformatf("%s_busy_cycles", tag), n, ROWS + 1);
    model_step();
    compare_board(tag);
  endtask

  initial begin
    logic [31:0] d;
    int          n;
    int          cyc, t1, t2, g0;
    logic [15:0] last_g;

    bus0.lg_we = 1'b0; bus0.lg_addr = '0; bus0.lg_din = '0;
    bus1.lg_we = 1'b0; bus1.lg_addr = '0; bus1.lg_din = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < ROWS; r++) mb[r] = 32'h0;
    mgen = 0;
    mwr_err = 1'b0;

    rd(0, 7'h00, d); check("rst_row0", d, 32'h0);
    rd(0, 7'h40, d); check("rst_ctrl", d, 32'h0);
    rd(0, 7'h44, d); check("rst_status", d, 32'h0);
    rd(0, 7'h48, d); check("rst_period", d, 32'h0);

    // Blinker
    mb[5] = 32'h0000_0070;
    load_board();
    step_check("blinker");
    rd(0, 7'h14, d); check("blinker_row5_const", d, 32'h0000_0020);
    rd(0, 7'h44, d); check("blinker_status_const", d, 32'h0001_0000);

    // Edge columns
    for (int r = 0; r < ROWS; r++) mb[r] = 32'h0;
    mb[5] = 32'h8000_0003;
    load_board();
    step_check("edge");

    // Row write during CALC is dropped and flags wr_err
    for (int r = 0; r < ROWS; r++) mb[r] = $urandom() & $urandom();
    load_board();
    wr(0, 7'h40, 32'h1);
    wr(0, 7'h08, 32'hDEAD_BEEF);
    wait_idle(n);
    model_step();
    mwr_err = 1'b1;
    compare_board("wr_err");
    wr(0, 7'h44, 32'h2);
    mwr_err = 1'b0;
    rd(0, 7'h44, d); check("wr_err_clear", d, exp_status(1'b0));

    // Unmapped register
    wr(0, 7'h4C, 32'hFFFF_FFFF);
    rd(0, 7'h4C, d); check("unmapped_4c", d, 32'h0);

    // Random soups
    for (int it = 0; it < 3; it++) begin
      for (int r = 0; r < ROWS; r++) mb[r] = $urandom() & $urandom();
      load_board();
      step_check($sformatf("rand%0d_a", it));
      step_check($sformatf("rand%0d_b", it));
    end

    // Free-running with PERIOD=3
    for (int r = 0; r < ROWS; r++) mb[r] = 32'h0;
    mb[5] = 32'h0000_0070;
    load_board();
    wr(0, 7'h48, 32'd3);
    rd(0, 7'h48, d); check("period_rd", d, 32'd3);
    g0 = mgen;
    last_g = 16'(mgen);
    wr(0, 7'h40, 32'h2);
    rd(0, 7'h40, d); check("ctrl_auto_rd", d, 32'h2);
    cyc = 0; t1 = -1; t2 = -1;
    while (cyc < 300 && t2 < 0) begin
      rd(0, 7'h44, d);
      if (d[31:16] != last_g) begin
        last_g = d[31:16];
        model_step();
        if (t1 < 0) t1 = cyc; else t2 = cyc;
      end
      if (t2 < 0) begin
        @(negedge clk);
        cyc++;
      end
    end
    check("auto_spacing", t2 - t1, ROWS + 1 + 3);
    check("auto_gen2", d[31:16], 32'(16'(g0 + 2)));
    rd(0, 7'h14, d); check("auto_row5_gen2", d, mb[5]);
    check("auto_row5_const", d, 32'h0000_0070);
    repeat (5) @(negedge clk);
    wr(0, 7'h40, 32'h0);
    rd(0, 7'h44, d); check("auto_off_busy", {31'h0, d[0]}, 32'h1);
    rd(0, 7'h14, d); check("calc_reads_old", d, mb[5]);
    wait_idle(n);
    model_step();
    compare_board("auto_stop");
    repeat (40) @(negedge clk);
    rd(0, 7'h44, d); check("auto_stopped_gen", d, exp_status(1'b0));
    check("auto_stopped_plus3", d[31:16], 32'(16'(g0 + 3)));

    // Generation wrap with GEN_W=2, plus out-of-range row on a short board
    rd(1, 7'h44, d); check("w2_gen0", d, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      wr(1, 7'h40, 32'h1);
      repeat (8) @(negedge clk);
      rd(1, 7'h44, d);
      check($sformatf("w2_gen%0d", k), d, 32'(k % 4) << 16);
    end
    wr(1, 7'h14, 32'h1234_5678);
    rd(1, 7'h14, d); check("w2_row_oob", d, 32'h0);
    wr(1, 7'h04, 32'h1234_5678);
    rd(1, 7'h04, d); check("w2_row1", d, 32'h1234_5678);

    // Reset in the middle of a step
    for (int r = 0; r < ROWS; r++) mb[r] = $urandom();
    load_board();
    wr(0, 7'h48, 32'd7);
    wr(0, 7'h40, 32'h3);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < ROWS; r++) mb[r] = 32'h0;
    mgen = 0;
    mwr_err = 1'b0;
    repeat (ROWS + 4) @(negedge clk);
    compare_board("mid_rst");
    rd(0, 7'h40, d); check("mid_rst_ctrl", d, 32'h0);
    rd(0, 7'h48, d); check("mid_rst_period", d, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
